bc_input_port: RTL and testbench

Input-device interface for the basic computer: it buffers bytes from an external device and presents them to the CPU as the INPR register and the FGI input flag. It sits directly upstream of the CPU top, driving its `FGI` input. It also supplies the 8-bit INPR value that the CPU's INP instruction loads into AC[7:0]. Bytes arrive over a valid/ready handshake into a small FIFO. The FIFO head is moved into INPR whenever FGI is clear, and the CPU's INP execution acknowledges and clears FGI.

---
 rtl/bc_io_pkg.sv | 20 ++
 rtl/bc_input_port_if.sv | 27 ++
 rtl/bc_sync_fifo.sv | 61 ++++++
 rtl/bc_input_port.sv | 102 ++++++++++
 tb/tb_bc_input_port.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bc_io_pkg.sv
// Shared types and helpers for the basic-computer input port: default data
// width, the FGI state type and the even-parity check.
package bc_io_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int PAR_MAX_W      = 64;

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } fgi_state_t;

  // Even parity holds when the data bits and the parity bit XOR to zero;
  // zero-extension of narrower data leaves the XOR unchanged.
  function automatic logic even_parity_ok(input logic [PAR_MAX_W-1:0] data,
                                          input logic                 parity);
    return ~(^{data, parity});
  endfunction

endpackage

// File: rtl/bc_input_port_if.sv
// Device-side valid/ready byte handshake feeding the input port.
interface bc_input_port_if
  import bc_io_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
);

  logic [DATA_W-1:0] dev_data;
  logic              dev_parity;
  logic              dev_valid;
  logic              dev_ready;

  modport master (
    output dev_data,
    output dev_parity,
    output dev_valid,
    input  dev_ready
  );

  modport slave (
    input  dev_data,
    input  dev_parity,
    input  dev_valid,
    output dev_ready
  );

endinterface

// File: rtl/bc_sync_fifo.sv
// Single-clock FIFO with occupancy count; DEPTH must be a power of two so the
// pointers wrap naturally.
module bc_sync_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          pop_data,
  output logic [$clog2(DEPTH+1)-1:0] fill,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH+1);

  logic [DATA_W-1:0] storage [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]     fill_q, fill_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   fill_d = fill_q + FW'(1);
      2'b01:   fill_d = fill_q - FW'(1);
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // Storage carries no reset: an empty count makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (push) storage[wr_ptr_q] <= push_data;
  end

  assign pop_data = storage[rd_ptr_q];
  assign fill     = fill_q;
  assign full     = (fill_q == FW'(DEPTH));
  assign empty    = (fill_q == '0);

endmodule

// File: rtl/bc_input_port.sv
// Input port of the basic computer: device bytes are queued in a FIFO and
// handed to the CPU through INPR/FGI. Optional parity check: BC_INPUT_PARITY_EN.
module bc_input_port
  import bc_io_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  bc_input_port_if.slave             dev,
  input  logic                       inp_ack,
  output logic [DATA_W-1:0]          INPR,
  output logic                       FGI,
  output logic                       PAR_ERR,
  output logic [$clog2(DEPTH+1)-1:0] fill
);

  fgi_state_t        state_q, state_d;
  logic [DATA_W-1:0] inpr_q, inpr_d;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              accept;
  logic              push;
  logic              pop;

  assign dev.dev_ready = ~fifo_full;
  assign accept        = dev.dev_valid & dev.dev_ready;

`ifdef BC_INPUT_PARITY_EN
  logic par_ok;
  logic par_err_q, par_err_d;

  // A bad byte still completes the handshake but never enters the FIFO.
  assign par_ok    = even_parity_ok(PAR_MAX_W'(dev.dev_data), dev.dev_parity);
  assign push      = accept & par_ok;
  assign par_err_d = par_err_q | (accept & ~par_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_err_q <= 1'b0;
    else        par_err_q <= par_err_d;
  end

  assign PAR_ERR = par_err_q;
`else
  logic unused_parity;

  assign unused_parity = dev.dev_parity;
  assign push          = accept;
  assign PAR_ERR       = 1'b0;
`endif

  bc_sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (dev.dev_data),
    .pop       (pop),
    .pop_data  (fifo_head),
    .fill      (fill),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Loading only from IDLE guarantees FGI drops for a cycle after every ack.
  always_comb begin
    state_d = state_q;
    inpr_d  = inpr_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          inpr_d  = fifo_head;
          state_d = FULL;
        end
      end
      FULL: begin
        if (inp_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      inpr_q  <= '0;
    end else begin
      state_q <= state_d;
      inpr_q  <= inpr_d;
    end
  end

  assign INPR = inpr_q;
  assign FGI  = (state_q == FULL);

endmodule

// File: tb/tb_bc_input_port.sv
// Randomized scoreboard bench for bc_input_port against a queue-based model.
module tb_bc_input_port;
  import bc_io_pkg::*;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 8;
  localparam int FW     = $clog2(DEPTH+1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              inp_ack = 1'b0;
  logic [DATA_W-1:0] INPR;
  logic              FGI;
  logic              PAR_ERR;
  logic [FW-1:0]     fill;

  bc_input_port_if #(.DATA_W(DATA_W)) dev_if ();

  bc_input_port #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .dev     (dev_if.slave),
    .inp_ack (inp_ack),
    .INPR    (INPR),
    .FGI     (FGI),
    .PAR_ERR (PAR_ERR),
    .fill    (fill)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  // Reference model: FIFO contents as a queue, flag and INPR as plain values.
  logic [DATA_W-1:0] m_q[$];
  logic [DATA_W-1:0] exp_q[$];
  bit                m_fgi;
  logic [DATA_W-1:0] m_inpr;
  bit                m_perr;

  function automatic bit m_par_ok(logic [DATA_W-1:0] d, logic p);
`ifdef BC_INPUT_PARITY_EN
    int ones = int'(p);
    for (int i = 0; i < DATA_W; i++) ones += int'(d[i]);
    return (ones % 2) == 0;
`else
    return 1'b1;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    bit                acc;
    bit                ok;
    logic [DATA_W-1:0] b;
    if (!rst_n) begin
      m_q.delete();
      exp_q.delete();
      m_fgi  = 1'b0;
      m_inpr = '0;
      m_perr = 1'b0;
    end else begin
      acc = dev_if.dev_valid && (m_q.size() != DEPTH);
      ok  = m_par_ok(dev_if.dev_data, dev_if.dev_parity);
      if (m_fgi) begin
        if (inp_ack) m_fgi = 1'b0;
      end else if (m_q.size() > 0) begin
        b      = m_q.pop_front();
        m_inpr = b;
        m_fgi  = 1'b1;
        exp_q.push_back(b);
      end
      if (acc && ok)  m_q.push_back(dev_if.dev_data);
      if (acc && !ok) m_perr = 1'b1;
    end
  end

  bit fgi_prev = 1'b0;

  always @(negedge clk) begin : monitor
    if (rst_n) begin
      check("fgi", FGI, m_fgi);
      check("fill", fill, m_q.size());
      check("dev_ready", dev_if.dev_ready, m_q.size() != DEPTH);
      check("par_err", PAR_ERR, m_perr);
      check("inpr_model", INPR, m_inpr);
      if (FGI && !fgi_prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL load_order: FGI rose with INPR=0x%0h, expected no load", INPR);
        end else begin
          check("load_order", INPR, exp_q.pop_front());
        end
      end
    end
    fgi_prev = FGI;
  end

  function automatic logic good_par(logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic p,
                      input logic a, output bit acc);
    dev_if.dev_valid  = v;
    dev_if.dev_data   = d;
    dev_if.dev_parity = p;
    inp_ack           = a;
    acc = v && dev_if.dev_ready;
    @(negedge clk);
  endtask

  task automatic send(input logic [DATA_W-1:0] d, input logic p);
    bit acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) step(1'b1, d, p, 1'b0, acc);
    if (!acc) begin
      checks++;
      $display("FAIL send_timeout: byte 0x%0h not accepted within 50 cycles", d);
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, acc);
  endtask

  task automatic drain();
    bit acc;
    for (int i = 0; i < 60; i++) begin
      if (fill == 0 && !FGI) break;
      step(1'b0, '0, 1'b0, FGI, acc);
    end
    check("drain_done", {fill, FGI}, '0);
  endtask

  initial begin : stim
    bit acc;
    bit pending;
    logic [DATA_W-1:0] d;
    dev_if.dev_valid  = 1'b0;
    dev_if.dev_data   = '0;
    dev_if.dev_parity = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_fgi", FGI, 0);
    check("rst_inpr", INPR, 0);
    check("rst_fill", fill, 0);
    check("rst_par_err", PAR_ERR, 0);
    check("rst_ready", dev_if.dev_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Single byte: two-edge latency to FGI.
    send(8'h41, good_par(8'h41));
    check("t1_fgi_after_accept", FGI, 0);
    idle(1);
    check("t1_fgi", FGI, 1);
    check("t1_inpr", INPR, 8'h41);
    check("t1_fill", fill, 0);
    step(1'b0, '0, 1'b0, 1'b1, acc);
    idle(1);

    // Ack and reload with one low cycle between bytes.
    send(8'h10, good_par(8'h10));
    send(8'h20, good_par(8'h20));
    check("t2_inpr_first", INPR, 8'h10);
    step(1'b0, '0, 1'b0, 1'b1, acc);
    check("t2_fgi_low", FGI, 0);
    check("t2_inpr_kept", INPR, 8'h10);
    idle(1);
    check("t2_fgi_reload", FGI, 1);
    check("t2_inpr_reload", INPR, 8'h20);
    drain();

    // Backpressure and pointer wrap.
    for (int b = 1; b <= 5; b++) send(DATA_W'(b), good_par(DATA_W'(b)));
    check("t3_inpr", INPR, 8'h01);
    check("t3_fill_full", fill, DEPTH);
    check("t3_ready_low", dev_if.dev_ready, 0);
    step(1'b1, 8'h06, good_par(8'h06), 1'b0, acc);
    check("t3_stalled", acc, 0);
    pending = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step(pending, 8'h06, good_par(8'h06), FGI && (i % 3 == 0), acc);
      if (acc) pending = 1'b0;
    end
    check("t3_sixth_accepted", pending, 0);
    drain();

    // Push and pop on the same edge.
    send(8'hA1, good_par(8'hA1));
    send(8'hB2, good_par(8'hB2));
    send(8'hC3, good_par(8'hC3));
    step(1'b0, '0, 1'b0, 1'b1, acc);
    check("t4_fill_before", fill, 2);
    check("t4_fgi_low", FGI, 0);
    step(1'b1, 8'hD4, good_par(8'hD4), 1'b0, acc);
    check("t4_fill_same", fill, 2);
    check("t4_inpr", INPR, 8'hB2);
    drain();

    // Parity error handling.
    send(8'h03, 1'b1);
    idle(2);
`ifdef BC_INPUT_PARITY_EN
    check("t5_par_err", PAR_ERR, 1);
    check("t5_dropped", FGI, 0);
    send(8'h03, 1'b0);
    idle(1);
    check("t5_good_fgi", FGI, 1);
    check("t5_good_inpr", INPR, 8'h03);
`else
    check("t5_par_err_off", PAR_ERR, 0);
    check("t5_delivered_fgi", FGI, 1);
    check("t5_delivered_inpr", INPR, 8'h03);
`endif
    drain();

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      d = DATA_W'($urandom);
      step($urandom_range(0, 1) == 1, d,
           good_par(d) ^ ($urandom_range(0, 7) == 0), $urandom_range(0, 2) == 0, acc);
    end
    drain();

    // Asynchronous reset mid-operation.
    for (int b = 0; b < 4; b++) send(DATA_W'(8'h70 + b), good_par(DATA_W'(8'h70 + b)));
    idle(1);
    check("t6_fill_before", fill, 3);
    check("t6_fgi_before", FGI, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_fgi", FGI, 0);
    check("t6_inpr", INPR, 0);
    check("t6_fill", fill, 0);
    check("t6_par_err", PAR_ERR, 0);
    check("t6_ready", dev_if.dev_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h5A, good_par(8'h5A));
    idle(2);
    check("t6_after_inpr", INPR, 8'h5A);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
